// File: rtl/fir_feeder.sv
// fir_feeder: FIFO-buffered sample sequencer that drives the fir core start/done handshake.
// Optional feature: define FIR_FEEDER_DROP_CNT_EN to add the saturating drop_cnt port.
module fir_feeder #(
    parameter int BITS    = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [BITS-1:0] in_data,
    output logic            in_ready,
    output logic            fir_start,
    output logic [BITS-1:0] fir_x,
    input  logic            fir_done,
    input  logic [BITS-1:0] fir_y,
    output logic            out_valid,
    output logic [BITS-1:0] out_data,
    output logic            busy,
    output logic            timeout_err
`ifdef FIR_FEEDER_DROP_CNT_EN
    ,
    output logic [7:0]      drop_cnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic            done_prev_q, done_prev_d;
    logic            in_ready_q, in_ready_d;
    logic            fir_start_q, fir_start_d;
    logic [BITS-1:0] fir_x_q, fir_x_d;
    logic            out_valid_q, out_valid_d;
    logic [BITS-1:0] out_data_q, out_data_d;
    logic            busy_q, busy_d;
    logic            timeout_err_q, timeout_err_d;

    logic push;
    logic pop;
    logic done_rise;
    logic complete;
    logic abort;

    always_comb begin
        push      = in_valid && in_ready_q;
        done_rise = fir_done && !done_prev_q;
        complete  = (state_q == WAIT) && done_rise;
        // Completion wins over an abort landing on the same cycle.
        abort     = (state_q == WAIT) && !done_rise && (wdog_q == WD_LAST);
        pop       = complete || abort;

        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        done_prev_d = fir_done;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        state_d       = state_q;
        fir_x_d       = fir_x_q;
        wdog_d        = wdog_q;
        out_valid_d   = 1'b0;
        out_data_d    = out_data_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    fir_x_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (complete) begin
                    out_data_d  = fir_y;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (abort) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (count_d != FULL);
        busy_d      = (state_d != IDLE) || (count_d != '0);
        fir_start_d = (state_d == START);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wdog_q        <= '0;
            done_prev_q   <= 1'b0;
            in_ready_q    <= 1'b0;
            fir_start_q   <= 1'b0;
            fir_x_q       <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            wdog_q        <= wdog_d;
            done_prev_q   <= done_prev_d;
            in_ready_q    <= in_ready_d;
            fir_start_q   <= fir_start_d;
            fir_x_q       <= fir_x_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign fir_start   = fir_start_q;
    assign fir_x       = fir_x_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

`ifdef FIR_FEEDER_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (in_valid && !in_ready_q && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fir_feeder.sv
// tb_fir_feeder: directed bench with a behavioural fir core model (y = x + 0x25).
// Optional feature: FIR_FEEDER_DROP_CNT_EN also exercises drop_cnt.
module tb_fir_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       fir_start;
    logic [7:0] fir_x;
    logic       fir_done = 1'b0;
    logic [7:0] fir_y = 8'h00;
    logic       out_valid;
    logic [7:0] out_data;
    logic       busy;
    logic       timeout_err;
`ifdef FIR_FEEDER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    fir_feeder #(
        .BITS(8),
        .DEPTH(4),
        .TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .fir_start(fir_start),
        .fir_x(fir_x),
        .fir_done(fir_done),
        .fir_y(fir_y),
        .out_valid(out_valid),
        .out_data(out_data),
        .busy(busy),
        .timeout_err(timeout_err)
`ifdef FIR_FEEDER_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Core model modes: 0 normal, 1 never done, 2 done stuck high.
    int         mode = 0;
    int         lat = 3;
    int         kick_req = 0;
    int         kick_ack = 0;
    int         cnt = 0;
    logic [7:0] cur_x = 8'h00;
    logic [7:0] xs[$];
    logic [7:0] ys[$];
    int         n_chk = 0;
    int         n_err = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            fir_done = 1'b0;
            cnt = 0;
        end else if (fir_start) begin
            xs.push_back(fir_x);
            cur_x = fir_x;
            cnt = 0;
            if (mode == 0) begin
                fir_done = 1'b0;
                cnt = lat;
            end else if (mode == 1) begin
                fir_done = 1'b0;
            end else begin
                fir_done = 1'b1;
            end
        end else if (kick_req != kick_ack) begin
            kick_ack = kick_req;
            fir_done = 1'b0;
            cnt = lat;
        end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                fir_done = 1'b1;
                fir_y = cur_x + 8'h25;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            ys.push_back(out_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k = 0;
        while (busy && k < max) begin
            step(1);
            k++;
        end
        check(tag, 32'(busy), 32'h0);
    endtask

    task automatic wait_starts(input string tag, input int n, input int max);
        int k = 0;
        while (xs.size() < n && k < max) begin
            step(1);
            k++;
        end
        check(tag, 32'(xs.size()), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int xbad;
        int ns;

        step(3);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_fir_start", 32'(fir_start), 32'h0);
        check("rst_fir_x", 32'(fir_x), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        rst_n = 1'b1;
        step(1);
        check("rel_in_ready", 32'(in_ready), 32'h1);

        // Single sample
        xs.delete();
        ys.delete();
        push(8'h05);
        check("s1_start_early", 32'(fir_start), 32'h0);
        step(1);
        check("s1_start", 32'(fir_start), 32'h1);
        check("s1_x", 32'(fir_x), 32'h05);
        step(1);
        check("s1_start_once", 32'(fir_start), 32'h0);
        k = 0;
        xbad = 0;
        while (!out_valid && k < 30) begin
            if (fir_x !== 8'h05) xbad++;
            step(1);
            k++;
        end
        check("s1_out_valid", 32'(out_valid), 32'h1);
        check("s1_out_data", 32'(out_data), 32'h2A);
        check("s1_x_stable", 32'(xbad), 32'h0);
        step(1);
        check("s1_ov_pulse", 32'(out_valid), 32'h0);
        check("s1_out_hold", 32'(out_data), 32'h2A);
        check("s1_n_start", 32'(xs.size()), 32'h1);
        check("s1_n_out", 32'(ys.size()), 32'h1);

        // Ordering
        xs.delete();
        ys.delete();
        for (int i = 1; i <= 4; i++) push(8'(i));
        wait_idle("ord_idle", 200);
        step(1);
        check("ord_n_start", 32'(xs.size()), 32'h4);
        check("ord_n_out", 32'(ys.size()), 32'h4);
        for (int i = 0; i < 4; i++) begin
            check("ord_x", 32'(xs[i]), 32'(i + 1));
            check("ord_y", 32'(ys[i]), 32'(8'h26 + i));
        end

        // Overflow with a stalled core
        xs.delete();
        ys.delete();
        mode = 1;
        for (int i = 0; i < 4; i++) push(8'(8'h31 + i));
        check("ovf_full", 32'(in_ready), 32'h0);
        push(8'h35);
        check("ovf_still_full", 32'(in_ready), 32'h0);
`ifdef FIR_FEEDER_DROP_CNT_EN
        check("ovf_drop_cnt", 32'(drop_cnt), 32'h1);
`endif
        step(3);
        check("ovf_stalled", 32'(xs.size()), 32'h1);
        mode = 0;
        kick_req++;
        wait_idle("ovf_idle", 300);
        step(1);
        check("ovf_n_start", 32'(xs.size()), 32'h4);
        check("ovf_n_out", 32'(ys.size()), 32'h4);
        for (int i = 0; i < 4; i++) begin
            check("ovf_x", 32'(xs[i]), 32'(8'h31 + i));
            check("ovf_y", 32'(ys[i]), 32'(8'h56 + i));
        end

        // Done stuck high
        xs.delete();
        ys.delete();
        mode = 2;
        push(8'h40);
        push(8'h41);
        step(40);
        check("stk_no_err_yet", 32'(timeout_err), 32'h0);
        check("stk_no_out_yet", 32'(ys.size()), 32'h0);
        k = 0;
        while (!timeout_err && k < 60) begin
            step(1);
            k++;
        end
        check("stk_timeout", 32'(timeout_err), 32'h1);
        wait_starts("stk_next_start", 2, 10);
        check("stk_no_out", 32'(ys.size()), 32'h0);
        check("stk_x2", 32'(xs[1]), 32'h41);
        mode = 0;
        kick_req++;
        wait_idle("stk_idle", 100);
        step(1);
        check("stk_n_out", 32'(ys.size()), 32'h1);
        check("stk_y", 32'(ys[0]), 32'h66);
        check("stk_err_sticky", 32'(timeout_err), 32'h1);

        // Timeout recovery
        xs.delete();
        ys.delete();
        mode = 1;
        push(8'h10);
        push(8'h11);
        wait_starts("rec_first_start", 1, 10);
        mode = 0;
        wait_idle("rec_idle", 200);
        step(1);
        check("rec_n_start", 32'(xs.size()), 32'h2);
        check("rec_n_out", 32'(ys.size()), 32'h1);
        check("rec_y", 32'(ys[0]), 32'h36);
        check("rec_err", 32'(timeout_err), 32'h1);

        // Reset mid-WAIT with two samples queued
        xs.delete();
        ys.delete();
        mode = 1;
        push(8'h50);
        push(8'h51);
        push(8'h52);
        step(3);
        check("mr_busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b0;
        step(1);
        check("mr_in_ready", 32'(in_ready), 32'h0);
        check("mr_fir_start", 32'(fir_start), 32'h0);
        check("mr_fir_x", 32'(fir_x), 32'h0);
        check("mr_out_valid", 32'(out_valid), 32'h0);
        check("mr_out_data", 32'(out_data), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_timeout_err", 32'(timeout_err), 32'h0);
`ifdef FIR_FEEDER_DROP_CNT_EN
        check("mr_drop_cnt", 32'(drop_cnt), 32'h0);
`endif
        rst_n = 1'b1;
        mode = 0;
        ns = xs.size();
        step(10);
        check("mr_no_start", 32'(xs.size()), 32'(ns));
        check("mr_empty", 32'(busy), 32'h0);
        check("mr_ready", 32'(in_ready), 32'h1);
        ys.delete();
        push(8'h60);
        wait_idle("mr_idle", 100);
        step(1);
        check("mr_n_out", 32'(ys.size()), 32'h1);
        check("mr_y", 32'(ys[0]), 32'h85);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fir_feeder.md
# fir_feeder

Sample sequencer that sits directly upstream of the `fir` core. It accepts input samples on a valid/ready port and buffers them in a small FIFO. It presents one sample at a time to the core with a one-cycle `start` pulse, holds `x` stable until the core's `done` rises, and republishes `y` as a one-cycle `out_valid` strobe. A watchdog aborts an operation whose `done` never arrives.

## Interface
- `BITS`, 8, sample and result width; matches the core's `BITS`.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64, maximum WAIT cycles before abort; ≥4.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  sample offered.
- `in_data`  in  BITS  sample value.
- `in_ready`  out  1  FIFO not full; registered occupancy only.
- `fir_start`  out  1  one-cycle start pulse to the core.
- `fir_x`  out  BITS  sample presented to the core.
- `fir_done`  in  1  core completion level.
- `fir_y`  in  BITS  core result.
- `out_valid`  out  1  one-cycle result strobe.
- `out_data`  out  BITS  last captured result; holds between strobes.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.
- `timeout_err`  out  1  sticky watchdog flag.
- `drop_cnt`  out  8  present only with `FIR_FEEDER_DROP_CNT_EN`.

## Operation
- Reset (`rst_n`=0 at a posedge) returns every output to 0: `in_ready`, `fir_start`, `fir_x`, `out_valid`, `out_data`, `busy`, `timeout_err`, `drop_cnt`. After release, `in_ready` becomes 1.
- FIFO:
  - A push occurs when `in_valid && in_ready`.
  - `in_valid && !in_ready` discards the sample. FIFO contents are unchanged.
  - The pointers wrap modulo `DEPTH`. An occupancy counter of width log2(DEPTH)+1 tracks fullness.
  - A pop occurs only on operation completion or abort, so a pop never hits an empty FIFO.
  - A push and a pop in the same cycle are both performed and occupancy is unchanged. When the FIFO is full, `in_ready`=0, so that cycle is a pop only.
- FSM states are IDLE, START, WAIT.
  - IDLE: if the FIFO is non-empty, load `fir_x` from the head and go to START.
  - START: `fir_start`=1 for this cycle only. Clear the watchdog counter and go to WAIT.
  - WAIT:
    - Completion is a rising edge of `fir_done`, i.e. `fir_done`=1 with the registered previous `fir_done`=0. A level held high from an earlier operation never completes the operation.
    - On completion: `out_data` ← `fir_y`, `out_valid`=1 for the next cycle, pop the FIFO, go to IDLE.
    - Watchdog: the counter increments each WAIT cycle. When it reaches `TIMEOUT` without completion: set `timeout_err`, pop the sample, suppress `out_valid`, go to IDLE.
- `fir_x` is stable from the START entry edge until the next IDLE→START transition.
- Samples reach the core in push order. Results emerge in the same order. Aborted samples produce no result.
- `timeout_err` clears only on reset.

## Timing
- All outputs are registered, or are decoded from the state register only.
- Push at edge t into an empty FIFO with the FSM in IDLE: `fir_start` is high from edge t+1 to edge t+2.
- Rising `fir_done` sampled at edge d: `out_valid` and the new `out_data` appear at d and last one cycle.
- The next start pulse comes at the earliest at edge d+1 (IDLE at d, START at d+1).
- Throughput is one sample per core latency + 2 cycles.
- `in_ready` reflects occupancy after the previous edge. A slot freed by a pop at edge e is accepted at edge e+1 at the earliest.
- Reset mid-operation: FIFO emptied, FSM to IDLE, and `fir_start` and `out_valid` low after the reset edge. The core shares `rst_n`.

## Configuration
- `FIR_FEEDER_DROP_CNT_EN` defined:
  - Adds the `drop_cnt` port, an 8-bit counter.
  - Increments on each `in_valid && !in_ready` cycle and saturates at 255.
  - Cleared by reset.
- `FIR_FEEDER_DROP_CNT_EN` undefined: the port and counter are absent, and drops are silent. All other behaviour is identical.

## Test plan
- Single sample: push 0x05 with the core model raising `fir_done` 3 cycles after start and `y`=0x2A. Required: `fir_start` pulses exactly once, 1 cycle after the push; `fir_x`=0x05 throughout WAIT; `out_valid` pulses once with `out_data`=0x2A.
- Ordering: push 0x01, 0x02, 0x03, 0x04 back-to-back. Required: the core sees `fir_x` in the order 0x01→0x04; 4 `out_valid` strobes in order; `busy` falls after the last strobe.
- Overflow: stall the core, then push 5 samples. Required: `in_ready`=0 after the 4th push; the 5th sample is lost; `drop_cnt`=1 with the macro defined; the first 4 samples complete once the core is released.
- Stuck-high done: hold `fir_done`=1 across two operations. Required: no completion until `fir_done` goes 0→1; otherwise `timeout_err`=1 after 64 WAIT cycles with no `out_valid`; the next queued sample still starts.
- Timeout recovery: the core never asserts `fir_done` for sample 0x10, then behaves normally for 0x11. Required: `timeout_err` stays 1; 0x10 yields no result; 0x11 yields one `out_valid`.
- Reset mid-WAIT: assert `rst_n`=0 for one edge during WAIT with 2 samples queued. Required: all outputs 0 after the edge; FIFO empty; no `fir_start` until a new push.
